sram_port_arbiter: RTL and testbench

Parametrised successor to the fixed `sram_sel` mux in the decompressor top level. It arbitrates the single read/write SRAM port among `NUM_CLIENTS` engines (VGA controller, decompressor stages, loaders) using registered round-robin grants and a per-owner burst limit. Read data is returned to the client that issued the read, tracked through a latency pipeline, so reads in flight survive grant hand-off. It sits between the client engines and the top-level `sram_*` pins.

---
 rtl/sram_port_arbiter_pkg.sv | 16 +
 rtl/sram_port_arbiter_rr_pick.sv | 28 ++
 rtl/sram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and helpers for the SRAM port arbiter: FSM state encoding and
// the owner-index width derived from the client count.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_HANDOFF = 2'd2
   } arb_state_t;

   // Owner index width; never narrower than one bit so a 1-bit select stays legal.
   function automatic int owner_w(input int num_clients);
      return (num_clients < 2) ? 1 : $clog2(num_clients);
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the last
// owner (wrapping), with the last owner itself searched last.
module rr_pick #(
   parameter int N  = 4,
   parameter int OW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [OW-1:0] i_last,
   output logic [OW-1:0] o_idx,
   output logic          o_any
);

   always_comb begin
      int c;
      c     = 0;
      o_idx = '0;
      o_any = 1'b0;
      // Walk from farthest to nearest so the nearest match overwrites last.
      for (int k = N; k >= 1; k--) begin
         c = (int'(i_last) + k) % N;
         if (i_req[c]) begin
            o_idx = OW'(c);
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for the shared SRAM read/write port with a per-owner
// burst limit and a read-tag pipeline that routes returning data to its issuer.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant held, waiting for any request
// GRANT   | one client owns the port, burst counter running
// HANDOFF | one dead cycle with no grant before the next pick
module sram_port_arbiter #(
   parameter int AW          = 20,
   parameter int DW          = 16,
   parameter int NUM_CLIENTS = 4,
   parameter int RD_LATENCY  = 1,
   parameter int MAX_BURST   = 64
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_CLIENTS-1:0]         cli_req,
   output logic [NUM_CLIENTS-1:0]         cli_gnt,
   input  logic [NUM_CLIENTS-1:0]         cli_rd_en,
   input  logic [NUM_CLIENTS*AW-1:0]      cli_raddr,
   input  logic [NUM_CLIENTS-1:0]         cli_wr_enable,
   input  logic [NUM_CLIENTS*AW-1:0]      cli_waddr,
   input  logic [NUM_CLIENTS*DW-1:0]      cli_wdata,
   output logic [NUM_CLIENTS-1:0]         cli_rvalid,
   output logic [DW-1:0]                  cli_rdata,
   output logic [AW-1:0]                  sram_raddr,
   input  logic [DW-1:0]                  sram_rdata,
   output logic [AW-1:0]                  sram_waddr,
   output logic [DW-1:0]                  sram_wdata,
   output logic                           sram_wr_enable,
   output logic [$clog2(NUM_CLIENTS)-1:0] owner,
   output logic                           busy
);
   import sram_arb_pkg::*;

   localparam int OW = owner_w(NUM_CLIENTS);
   localparam int BW = (MAX_BURST <= 2) ? 1 : $clog2(MAX_BURST);
   localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
   localparam int LAST_STG = RD_LATENCY - 1;

   arb_state_t             r_state;
   logic [NUM_CLIENTS-1:0] r_gnt;
   logic [OW-1:0]          r_owner;
   logic [BW-1:0]          r_burst_cnt;
   logic [RD_LATENCY-1:0]  r_pipe_v;
   logic [OW-1:0]          r_pipe_tag [RD_LATENCY];

   logic [OW-1:0]          w_pick_idx;
   logic                   w_pick_any;
   logic [NUM_CLIENTS-1:0] w_pick_oh;
   logic                   w_sel_valid;
   logic                   w_rd_issue;
   logic                   w_others;
   logic                   w_preempt;

   rr_pick #(
      .N  (NUM_CLIENTS),
      .OW (OW)
   ) u_rr_pick (
      .i_req  (cli_req),
      .i_last (r_owner),
      .o_idx  (w_pick_idx),
      .o_any  (w_pick_any)
   );

   always_comb begin
      w_pick_oh = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (w_pick_idx == OW'(i)) w_pick_oh[i] = 1'b1;
      end
   end

   assign w_sel_valid = r_gnt[r_owner] & cli_req[r_owner];
   assign w_rd_issue  = w_sel_valid & cli_rd_en[r_owner];
   assign w_others    = |(cli_req & ~r_gnt);
   assign w_preempt   = (r_burst_cnt == BURST_LAST) & w_others;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_gnt       <= '0;
         r_owner     <= OW'(NUM_CLIENTS - 1);
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HANDOFF: begin
               if (w_pick_any) begin
                  r_state     <= ST_GRANT;
                  r_owner     <= w_pick_idx;
                  r_gnt       <= w_pick_oh;
                  r_burst_cnt <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (!cli_req[r_owner] || w_preempt) begin
                  r_state <= ST_HANDOFF;
                  r_gnt   <= '0;
               end else if (r_burst_cnt != BURST_LAST) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   // Mux is gated by the owner's live request so a dropped request cuts strobes immediately.
   always_comb begin
      sram_raddr     = '0;
      sram_waddr     = '0;
      sram_wdata     = '0;
      sram_wr_enable = 1'b0;
      if (w_sel_valid) begin
         for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (r_owner == OW'(i)) begin
               sram_raddr     = cli_raddr[i*AW +: AW];
               sram_waddr     = cli_waddr[i*AW +: AW];
               sram_wdata     = cli_wdata[i*DW +: DW];
               sram_wr_enable = cli_wr_enable[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe_v <= '0;
         for (int i = 0; i < RD_LATENCY; i++) r_pipe_tag[i] <= '0;
      end else begin
         r_pipe_v[0]   <= w_rd_issue;
         r_pipe_tag[0] <= r_owner;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe_v[i]   <= r_pipe_v[i-1];
            r_pipe_tag[i] <= r_pipe_tag[i-1];
         end
      end
   end

   always_comb begin
      cli_rvalid = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         if (r_pipe_v[LAST_STG] && (r_pipe_tag[LAST_STG] == OW'(i))) cli_rvalid[i] = 1'b1;
      end
   end

   assign cli_rdata = sram_rdata;
   assign cli_gnt   = r_gnt;
   assign owner     = r_owner;
   assign busy      = (|r_gnt) | (|r_pipe_v);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (N=4, RD_LATENCY=3, MAX_BURST=4):
// grant timing, round-robin rotation, read-tag return, gating and reset.
module tb_sram_port_arbiter;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    cli_req;
   logic [N-1:0]    cli_gnt;
   logic [N-1:0]    cli_rd_en;
   logic [N*AW-1:0] cli_raddr;
   logic [N-1:0]    cli_wr_enable;
   logic [N*AW-1:0] cli_waddr;
   logic [N*DW-1:0] cli_wdata;
   logic [N-1:0]    cli_rvalid;
   logic [DW-1:0]   cli_rdata;
   logic [AW-1:0]   sram_raddr;
   logic [DW-1:0]   sram_rdata;
   logic [AW-1:0]   sram_waddr;
   logic [DW-1:0]   sram_wdata;
   logic            sram_wr_enable;
   logic [1:0]      owner;
   logic            busy;

   int checks = 0;
   int errors = 0;

   sram_port_arbiter #(
      .AW(AW), .DW(DW), .NUM_CLIENTS(N), .RD_LATENCY(3), .MAX_BURST(4)
   ) dut (
      .clk(clk), .reset(reset), .cli_req(cli_req), .cli_gnt(cli_gnt),
      .cli_rd_en(cli_rd_en), .cli_raddr(cli_raddr), .cli_wr_enable(cli_wr_enable),
      .cli_waddr(cli_waddr), .cli_wdata(cli_wdata), .cli_rvalid(cli_rvalid),
      .cli_rdata(cli_rdata), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
      .sram_waddr(sram_waddr), .sram_wdata(sram_wdata), .sram_wr_enable(sram_wr_enable),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_sram_zero(input string tag);
      chk({tag, "_raddr"}, sram_raddr, 0);
      chk({tag, "_waddr"}, sram_waddr, 0);
      chk({tag, "_wdata"}, sram_wdata, 0);
      chk({tag, "_wren"},  sram_wr_enable, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rr_exp [5];
      rr_exp = '{3, 0, 1, 2, 3};
      reset = 1'b1;
      cli_req = '0; cli_rd_en = '0; cli_raddr = '0;
      cli_wr_enable = '0; cli_waddr = '0; cli_wdata = '0;
      sram_rdata = 16'hBEEF;

      // Reset state
      tick(); tick();
      chk("rst_gnt", cli_gnt, 0);
      chk("rst_owner", owner, 3);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", cli_rvalid, 0);
      chk_sram_zero("rst");

      // Client 0 request at t, grant at t+1, read returns at t+4
      reset = 1'b0;
      cli_req = 4'b0001;
      cli_raddr[0*AW +: AW] = 20'h00010;
      #1;
      chk("req_t_gnt", cli_gnt, 0);
      chk("req_t_raddr", sram_raddr, 0);
      tick();
      cli_rd_en[0] = 1'b1;
      #1;
      chk("gnt0", cli_gnt, 4'b0001);
      chk("owner0", owner, 0);
      chk("raddr0", sram_raddr, 20'h00010);
      chk("busy0", busy, 1);
      tick();
      cli_rd_en[0] = 1'b0;
      #1;
      chk("rv0_lat1", cli_rvalid, 0);
      tick(); #1;
      chk("rv0_lat2", cli_rvalid, 0);
      tick(); #1;
      chk("rv0_lat3", cli_rvalid, 4'b0001);
      chk("rdata0", cli_rdata, 16'hBEEF);

      // Non-owner write strobe from client 3 must be ignored
      cli_waddr[0*AW +: AW] = 20'h00123;
      cli_wdata[0*DW +: DW] = 16'h5555;
      cli_wr_enable[0] = 1'b1;
      cli_waddr[3*AW +: AW] = 20'h00FFF;
      cli_wdata[3*DW +: DW] = 16'hAAAA;
      cli_wr_enable[3] = 1'b1;
      #1;
      chk("wr_waddr", sram_waddr, 20'h00123);
      chk("wr_wdata", sram_wdata, 16'h5555);
      chk("wr_en", sram_wr_enable, 1);
      tick();
      cli_wr_enable[0] = 1'b0;
      #1;
      chk("rv0_single", cli_rvalid, 0);
      chk("wr3_ignored_en", sram_wr_enable, 0);
      chk("wr3_ignored_addr", sram_waddr, 20'h00123);

      // Owner drops request: strobes gated same cycle, grant falls next cycle
      cli_req = 4'b0000;
      cli_wr_enable[3] = 1'b0;
      #1;
      chk("drop_gated_raddr", sram_raddr, 0);
      chk("drop_gated_waddr", sram_waddr, 0);
      chk("drop_gnt_still", cli_gnt, 4'b0001);
      tick();
      cli_req = 4'b0100;
      #1;
      chk("handoff_gnt", cli_gnt, 0);
      chk("handoff_busy", busy, 0);

      // Client 2 alone for 200 cycles: never preempted
      for (int i = 0; i < 200; i++) begin
         tick(); #1;
         chk("hold_gnt2", cli_gnt, 4'b0100);
      end
      cli_req = 4'b0000;
      tick(); #1;
      chk("rel2_handoff", cli_gnt, 0);
      tick(); #1;
      chk("rel2_idle", cli_gnt, 0);
      chk("rel2_owner", owner, 2);

      // All request: 4-cycle grants separated by one empty cycle, order 3,0,1,2,3
      cli_req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            tick(); #1;
            chk("rr_gnt", cli_gnt, 4'b0001 << rr_exp[g]);
         end
         tick(); #1;
         chk("rr_gap", cli_gnt, 0);
      end

      // Client 1 reads on its last granted cycle; data returns while 3 owns
      cli_req = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         tick(); #1;
         chk("e_gnt1", cli_gnt, 4'b0010);
      end
      tick();
      cli_rd_en[1] = 1'b1;
      cli_raddr[1*AW +: AW] = 20'h00ABC;
      #1;
      chk("e_gnt1_last", cli_gnt, 4'b0010);
      chk("e_raddr1", sram_raddr, 20'h00ABC);
      tick();
      cli_rd_en[1] = 1'b0;
      #1;
      chk("e_handoff", cli_gnt, 0);
      chk("e_rv_p1", cli_rvalid, 0);
      tick(); #1;
      chk("e_gnt3", cli_gnt, 4'b1000);
      chk("e_rv_p2", cli_rvalid, 0);
      tick();
      sram_rdata = 16'h1234;
      cli_rd_en[3] = 1'b1;
      cli_raddr[3*AW +: AW] = 20'h00333;
      #1;
      chk("e_gnt3_b", cli_gnt, 4'b1000);
      chk("e_rv1_p3", cli_rvalid, 4'b0010);
      chk("e_rdata1", cli_rdata, 16'h1234);

      // Two client-3 reads in flight, then reset while still granted
      tick(); #1;
      chk("f_rv_none", cli_rvalid, 0);
      tick();
      cli_rd_en[3] = 1'b0;
      reset = 1'b1;
      #1;
      chk("f_gnt3_before_rst", cli_gnt, 4'b1000);
      tick(); #1;
      chk("f_rst_gnt", cli_gnt, 0);
      chk("f_rst_rvalid", cli_rvalid, 0);
      chk("f_rst_busy", busy, 0);
      chk_sram_zero("f_rst");
      tick();
      reset = 1'b0;
      #1;
      chk("f_rst_rvalid2", cli_rvalid, 0);
      chk("f_rst_owner", owner, 3);
      tick(); #1;
      chk("f_post_gnt", cli_gnt, 4'b0010);
      chk("f_post_owner", owner, 1);
      chk("f_post_rvalid", cli_rvalid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
